// File: rtl/tqvp_waveforms_pkg.sv
// tqvp_waveforms: shared types and constants for the waveform plotter.
// Command kinds, sequencer states, register map and SSD1306 byte values.
package tqvp_waveforms_pkg;

  typedef enum logic [1:0] {
    K_SAMPLE = 2'd0,
    K_RAW    = 2'd1,
    K_SEL    = 2'd2
  } kind_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEL_CMD,
    S_PIXEL,
    S_SHIFT,
    S_DC_RESTORE
  } state_t;

  typedef struct packed {
    kind_t      kind;
    logic [7:0] data;
  } entry_t;

  localparam logic [3:0] A_SAMPLE = 4'h0;
  localparam logic [3:0] A_RAW    = 4'h1;
  localparam logic [3:0] A_CTRL   = 4'h2;
  localparam logic [3:0] A_SEL    = 4'h3;
  localparam logic [3:0] A_CLR    = 4'h4;
  localparam logic [3:0] A_STAT   = 4'h8;

  localparam logic [6:0] COL_HI   = 7'h02;
  localparam logic [6:0] COL_LO   = 7'h40;
  localparam logic [6:0] COL_EDGE = 7'h7E;

  localparam logic [7:0] CMD_PAGE   = 8'hB0;
  localparam logic [7:0] CMD_COL_LO = 8'h00;
  localparam logic [7:0] CMD_COL_HI = 8'h10;

  function automatic logic [6:0] pixel_col(
    input logic b,
    input logic last,
    input logic edg
  );
    if (edg && (b != last)) return COL_EDGE;
    else if (b)             return COL_HI;
    else                    return COL_LO;
  endfunction

endpackage

// File: rtl/tqvp_waveforms_if.sv
// tqvp_waveforms: TinyQV 8-bit register bus bundle.
// master = CPU side, slave = peripheral side.
interface tqvp_waveforms_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (
    output address, data_write, data_in,
    input  data_out
  );

  modport slave (
    input  address, data_write, data_in,
    output data_out
  );
endinterface

// File: rtl/tqvp_waveforms_fifo.sv
// tqvp_waveforms_fifo: synchronous FIFO with level/full/empty.
// A push while full is accepted only when a pop happens in the same cycle.
module tqvp_waveforms_fifo
  import tqvp_waveforms_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(entry_t),
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic [AW:0]  o_level,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_lvl;
  logic          w_push;
  logic          w_pop;

  assign o_level = r_lvl;
  assign o_full  = (r_lvl == (AW+1)'(DEPTH));
  assign o_empty = (r_lvl == '0);
  assign o_rdata = r_mem[r_rp];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_lvl <= r_lvl + 1'b1;
        2'b01:   r_lvl <= r_lvl - 1'b1;
        default: r_lvl <= r_lvl;
      endcase
    end
  end

endmodule

// File: rtl/tqvp_waveforms_mc.sv
// tqvp_waveforms_mc: multi-track SSD1306 waveform plotter on TinyQV.
// Tagged command FIFO feeds a sequencer driving an SPI master on uo_out.
module tqvp_waveforms_mc
  import tqvp_waveforms_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_TRACKS  = 4,
  parameter int PRESC_W     = 4,
  parameter int RESET_PRESC = 4,
  parameter bit CPOL        = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int LW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
  localparam int EW = $bits(entry_t);

  logic [PRESC_W-1:0] r_presc;
  logic r_dc_idle, r_cs_force, r_inv, r_edge, r_ovf;

  state_t r_state, nx_state, r_ret, nx_ret;
  entry_t r_ent, nx_ent, w_ent;
  logic [7:0] r_tx, nx_tx, r_bfr, nx_bfr, r_last, nx_last;
  logic [3:0] r_px, nx_px, r_half, nx_half;
  logic [1:0] r_idx, nx_idx;
  logic [2:0] r_track, nx_track;
  logic [PRESC_W-1:0] r_cnt, nx_cnt;
  logic r_sck, nx_sck, r_dc, nx_dc;

  logic w_push, w_pop, w_bad_sel, w_drop;
  logic w_full, w_empty, w_idle, w_cs_n;
  logic [EW-1:0] w_rdata;
  logic [LW-1:0] w_level;
  logic w_unused;

  assign w_unused = ^ui_in;

  always_comb begin
    w_push    = 1'b0;
    w_bad_sel = 1'b0;
    w_ent     = '{kind: K_SAMPLE, data: data_in};
    if (data_write) begin
      unique case (address)
        A_SAMPLE: w_push = 1'b1;
        A_RAW: begin
          w_push     = 1'b1;
          w_ent.kind = K_RAW;
        end
        A_SEL: begin
          w_ent = '{kind: K_SEL, data: {5'b0, data_in[2:0]}};
          if (int'(data_in[2:0]) >= NUM_TRACKS) w_bad_sel = 1'b1;
          else                                  w_push    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_drop = w_push && w_full && !w_pop;

  tqvp_waveforms_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_ent),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc    <= PRESC_W'(RESET_PRESC);
      r_dc_idle  <= 1'b0;
      r_cs_force <= 1'b1;
      r_inv      <= 1'b0;
      r_edge     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (data_write && address == A_CTRL) begin
        r_presc    <= PRESC_W'(data_in[3:0]);
        r_dc_idle  <= data_in[4];
        r_cs_force <= data_in[5];
        r_inv      <= data_in[6];
        r_edge     <= data_in[7];
      end
      if (data_write && address == A_CLR) r_ovf <= 1'b0;
      else if (w_drop || w_bad_sel)       r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ret   <= S_IDLE;
      r_ent   <= '0;
      r_tx    <= '0;
      r_bfr   <= '0;
      r_last  <= '0;
      r_px    <= '0;
      r_half  <= '0;
      r_idx   <= '0;
      r_track <= '0;
      r_cnt   <= '0;
      r_sck   <= CPOL;
      r_dc    <= 1'b0;
    end else begin
      r_state <= nx_state;
      r_ret   <= nx_ret;
      r_ent   <= nx_ent;
      r_tx    <= nx_tx;
      r_bfr   <= nx_bfr;
      r_last  <= nx_last;
      r_px    <= nx_px;
      r_half  <= nx_half;
      r_idx   <= nx_idx;
      r_track <= nx_track;
      r_cnt   <= nx_cnt;
      r_sck   <= nx_sck;
      r_dc    <= nx_dc;
    end
  end

  // Every byte-launching branch reloads the prescaler and half-bit count.
  always_comb begin
    nx_state = r_state;
    nx_ret   = r_ret;
    nx_ent   = r_ent;
    nx_tx    = r_tx;
    nx_bfr   = r_bfr;
    nx_last  = r_last;
    nx_px    = r_px;
    nx_half  = r_half;
    nx_idx   = r_idx;
    nx_track = r_track;
    nx_cnt   = r_cnt;
    nx_sck   = r_sck;
    nx_dc    = r_dc;
    w_pop    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop    = 1'b1;
          nx_ent   = entry_t'(w_rdata);
          nx_state = S_FETCH;
        end
      end
      S_FETCH: begin
        unique case (r_ent.kind)
          K_RAW: begin
            nx_tx    = r_ent.data;
            nx_dc    = r_dc_idle;
            nx_ret   = S_IDLE;
            nx_state = S_SHIFT;
            nx_cnt   = r_presc;
            nx_half  = '0;
          end
          K_SAMPLE: begin
            nx_bfr   = r_ent.data;
            nx_px    = 4'd8;
            nx_state = S_PIXEL;
          end
          K_SEL: begin
            nx_track = r_ent.data[2:0];
            nx_idx   = '0;
            nx_dc    = 1'b0;
            nx_state = S_SEL_CMD;
          end
          default: nx_state = S_IDLE;
        endcase
      end
      S_SEL_CMD: begin
        nx_ret   = S_SEL_CMD;
        nx_state = S_SHIFT;
        nx_cnt   = r_presc;
        nx_half  = '0;
        nx_idx   = r_idx + 2'd1;
        unique case (r_idx)
          2'd0: nx_tx = CMD_PAGE | {5'b0, r_track};
          2'd1: nx_tx = CMD_COL_LO;
          2'd2: nx_tx = CMD_COL_HI;
          default: begin
            nx_state = S_DC_RESTORE;
            nx_dc    = r_dc_idle;
            nx_idx   = r_idx;
          end
        endcase
      end
      S_PIXEL: begin
        if (r_px == 4'd0) begin
          nx_state = S_IDLE;
        end else begin
          nx_bfr  = {r_bfr[6:0], 1'b0};
          nx_px   = r_px - 4'd1;
          nx_tx   = {r_inv,
                     pixel_col(r_bfr[7], r_last[r_track], r_edge)};
          nx_last[r_track] = r_bfr[7];
          nx_ret   = S_PIXEL;
          nx_state = S_SHIFT;
          nx_cnt   = r_presc;
          nx_half  = '0;
        end
      end
      S_SHIFT: begin
        if (r_cnt == '0) begin
          nx_cnt  = r_presc;
          nx_sck  = ~r_sck;
          nx_half = r_half + 4'd1;
          if (r_half[0]) nx_tx = {r_tx[6:0], 1'b0};
          if (r_half == 4'd15) begin
            nx_sck   = CPOL;
            nx_state = r_ret;
          end
        end else begin
          nx_cnt = r_cnt - PRESC_W'(1);
        end
      end
      S_DC_RESTORE: nx_state = S_IDLE;
      default:      nx_state = S_IDLE;
    endcase
  end

  assign w_idle = (r_state == S_IDLE) && w_empty;
  assign w_cs_n = r_cs_force &
                  !(r_state inside {S_SHIFT, S_SEL_CMD, S_PIXEL, S_FETCH});

  assign uo_out = {3'b000, r_dc, w_cs_n, r_tx[7], r_sck, 1'b0};

  always_comb begin
    data_out = '0;
    if (address == A_STAT)
      data_out = {4'(w_level), 1'b0, r_ovf, w_full, w_idle};
  end

endmodule
